// File: rtl/uart_column_scheduler.sv
// Round-robin scheduler that shares one UART column transmitter between two
// matrix producers, snapshotting the winner and stepping through its columns.
module uart_column_scheduler #(
  parameter int CYCLES_PER_COLUMN = 88,
  parameter int GAP_CYCLES        = 4,
  parameter int NUM_COLUMNS       = 4
) (
  input  logic                uart_column_scheduler_clock,
  input  logic                uart_column_scheduler_reset_active_low,
  input  logic                req_0,
  input  logic                req_1,
  input  logic [127:0]        btint_a_0,
  input  logic [127:0]        btint_a_1,
  input  logic [127:0]        btint_b_0,
  input  logic [127:0]        btint_b_1,
  input  logic [31:0]         overflow_0,
  input  logic [31:0]         overflow_1,
  output logic                grant_0,
  output logic                grant_1,
  output logic                done_0,
  output logic                done_1,
  output logic                busy,
  output logic                transmitter_reset_active_low,
  output logic [127:0]        transmitter_input_btint_a,
  output logic [127:0]        transmitter_input_btint_b,
  output logic [31:0]         transmitter_input_overflow,
  output logic signed [31:0]  transmitter_column
);

  localparam int CNT_W = (CYCLES_PER_COLUMN > 2) ? $clog2(CYCLES_PER_COLUMN) : 1;
  localparam int COL_W = (NUM_COLUMNS > 2) ? $clog2(NUM_COLUMNS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_COLUMN - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLUMNS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE, GAP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COL_W-1:0]   col_q;
  logic [GAP_W-1:0]   gap_q;
  logic               owner_q;
  logic               rr_favour_q;
  logic               pick_1;

  // On a tie the favoured requester wins; otherwise whichever is asking.
  always_comb begin
    pick_1 = req_1;
    if (req_0 && req_1) pick_1 = rr_favour_q;
  end

  assign transmitter_column = signed'({{(32-COL_W){1'b0}}, col_q});

  always_ff @(posedge uart_column_scheduler_clock or negedge uart_column_scheduler_reset_active_low) begin
    if (!uart_column_scheduler_reset_active_low) begin
      state_q                      <= IDLE;
      cnt_q                        <= '0;
      col_q                        <= '0;
      gap_q                        <= '0;
      owner_q                      <= 1'b0;
      rr_favour_q                  <= 1'b0;
      grant_0                      <= 1'b0;
      grant_1                      <= 1'b0;
      done_0                       <= 1'b0;
      done_1                       <= 1'b0;
      busy                         <= 1'b0;
      transmitter_reset_active_low <= 1'b0;
      transmitter_input_btint_a    <= '0;
      transmitter_input_btint_b    <= '0;
      transmitter_input_overflow   <= '0;
    end else begin
      grant_0 <= 1'b0;
      grant_1 <= 1'b0;
      done_0  <= 1'b0;
      done_1  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_0 || req_1) begin
            transmitter_input_btint_a    <= pick_1 ? btint_a_1  : btint_a_0;
            transmitter_input_btint_b    <= pick_1 ? btint_b_1  : btint_b_0;
            transmitter_input_overflow   <= pick_1 ? overflow_1 : overflow_0;
            grant_0                      <= ~pick_1;
            grant_1                      <= pick_1;
            owner_q                      <= pick_1;
            cnt_q                        <= '0;
            col_q                        <= '0;
            transmitter_reset_active_low <= 1'b1;
            busy                         <= 1'b1;
            state_q                      <= SEND;
          end
        end
        SEND: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (col_q == COL_LAST) begin
              done_0                       <= ~owner_q;
              done_1                       <= owner_q;
              transmitter_reset_active_low <= 1'b0;
              col_q                        <= '0;
              state_q                      <= DONE;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          rr_favour_q <= ~owner_q;
          gap_q       <= '0;
          state_q     <= GAP;
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_column_scheduler.sv
// Directed bench for uart_column_scheduler: default build plus a minimal
// CYCLES_PER_COLUMN=2 / GAP_CYCLES=1 build sharing the clock and reset.
module tb_uart_column_scheduler;

  localparam int CPC = 88;
  localparam int GAPC = 4;
  localparam int NC = 4;
  localparam logic [127:0] PAT_A = 128'h0102030405060708090a0b0c0d0e0f10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_0 = 1'b0, req_1 = 1'b0;
  logic c_req_0 = 1'b0, c_req_1 = 1'b0;
  logic [127:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [31:0] o0 = '0, o1 = '0;

  logic grant_0, grant_1, done_0, done_1, busy, txrst;
  logic [127:0] tx_a, tx_b;
  logic [31:0] tx_o;
  logic signed [31:0] tx_col;

  logic c_grant_0, c_grant_1, c_done_0, c_done_1, c_busy, c_txrst;
  logic [127:0] c_tx_a, c_tx_b;
  logic [31:0] c_tx_o;
  logic signed [31:0] c_tx_col;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  typedef struct {
    int           id;
    logic [127:0] a;
    logic [127:0] b;
    logic [31:0]  ov;
  } job_t;
  job_t sb[$];

  always #5 clk = ~clk;

  uart_column_scheduler dut (
    .uart_column_scheduler_clock(clk),
    .uart_column_scheduler_reset_active_low(rst_n),
    .req_0(req_0), .req_1(req_1),
    .btint_a_0(a0), .btint_a_1(a1),
    .btint_b_0(b0), .btint_b_1(b1),
    .overflow_0(o0), .overflow_1(o1),
    .grant_0(grant_0), .grant_1(grant_1),
    .done_0(done_0), .done_1(done_1),
    .busy(busy),
    .transmitter_reset_active_low(txrst),
    .transmitter_input_btint_a(tx_a),
    .transmitter_input_btint_b(tx_b),
    .transmitter_input_overflow(tx_o),
    .transmitter_column(tx_col)
  );

  uart_column_scheduler #(.CYCLES_PER_COLUMN(2), .GAP_CYCLES(1), .NUM_COLUMNS(4)) dut_c (
    .uart_column_scheduler_clock(clk),
    .uart_column_scheduler_reset_active_low(rst_n),
    .req_0(c_req_0), .req_1(c_req_1),
    .btint_a_0(a0), .btint_a_1(a1),
    .btint_b_0(b0), .btint_b_1(b1),
    .overflow_0(o0), .overflow_1(o1),
    .grant_0(c_grant_0), .grant_1(c_grant_1),
    .done_0(c_done_0), .done_1(c_done_1),
    .busy(c_busy),
    .transmitter_reset_active_low(c_txrst),
    .transmitter_input_btint_a(c_tx_a),
    .transmitter_input_btint_b(c_tx_b),
    .transmitter_input_overflow(c_tx_o),
    .transmitter_column(c_tx_col)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(input int id);
    job_t e;
    e.id = id;
    e.a  = (id == 1) ? a1 : a0;
    e.b  = (id == 1) ? b1 : b0;
    e.ov = (id == 1) ? o1 : o0;
    sb.push_back(e);
  endtask

  // Waits for a grant, follows the whole job and retires the scoreboard head.
  task automatic run_job(input string tag, input bit drop, output int lat);
    job_t e;
    int bad;
    int got;
    bad = 0;
    lat = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'd0, 128'd1);
      return;
    end
    e = sb[0];
    do begin
      tick();
      lat++;
    end while (!(grant_0 || grant_1) && lat < 1000);
    chk({tag, "_grant_seen"}, grant_0 | grant_1, 1);
    got = grant_1 ? 1 : 0;
    chk({tag, "_grant_id"}, got, e.id);
    chk({tag, "_grant_excl"}, grant_0 & grant_1, 0);
    chk({tag, "_txrst_rel"}, txrst, 1);
    chk({tag, "_busy_hi"}, busy, 1);
    chk({tag, "_col0"}, tx_col, 0);
    if (drop) begin
      req_0 = 1'b0; req_1 = 1'b0;
      a0 = '1; a1 = '1; b0 = '1; b1 = '1; o0 = '1; o1 = '1;
    end
    for (int k = 1; k < NC * CPC; k++) begin
      tick();
      if (tx_col !== k / CPC) bad++;
      if (tx_a !== e.a || tx_b !== e.b || tx_o !== e.ov) bad++;
      if (done_0 || done_1 || grant_0 || grant_1) bad++;
      if (txrst !== 1'b1 || busy !== 1'b1) bad++;
      if (k % CPC == 0) chk({tag, "_col_step"}, tx_col, k / CPC);
    end
    chk({tag, "_send_steady"}, bad, 0);
    tick();
    chk({tag, "_done_0"}, done_0, (e.id == 0) ? 1 : 0);
    chk({tag, "_done_1"}, done_1, (e.id == 1) ? 1 : 0);
    chk({tag, "_done_txrst"}, txrst, 0);
    chk({tag, "_done_col"}, tx_col, 0);
    chk({tag, "_snap_a"}, tx_a, e.a);
    chk({tag, "_snap_b"}, tx_b, e.b);
    chk({tag, "_snap_ov"}, tx_o, e.ov);
    void'(sb.pop_front());
    bad = 0;
    for (int g = 0; g < GAPC; g++) begin
      tick();
      if (busy !== 1'b1 || txrst !== 1'b0 || done_0 || done_1 || grant_0 || grant_1) bad++;
    end
    chk({tag, "_gap"}, bad, 0);
    tick();
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    int n;
    // reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_txrst", txrst, 0);
    chk("rst_grants", {grant_0, grant_1, done_0, done_1}, 0);
    chk("rst_col", tx_col, 0);
    chk("rst_snap", tx_a | tx_b | tx_o, 0);
    rst_n = 1'b1;
    repeat (6) tick();

    // single requester, inputs overwritten one cycle after grant
    a0 = PAT_A; b0 = rnd128(); o0 = $urandom;
    req_0 = 1'b1;
    push(0);
    run_job("single", 1'b1, lat);
    chk("single_latency", lat, 1);

    // simultaneous requests after reset: 0, 1, 0
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    a0 = rnd128(); b0 = rnd128(); o0 = $urandom;
    a1 = rnd128(); b1 = rnd128(); o1 = $urandom;
    req_0 = 1'b1; req_1 = 1'b1;
    push(0); push(1); push(0);
    run_job("rr_a", 1'b0, lat);
    run_job("rr_b", 1'b0, lat);
    chk("rr_b_spacing", lat, 1);
    run_job("rr_c", 1'b1, lat);
    chk("rr_c_spacing", lat, 1);

    // reset in the middle of column 2
    a1 = rnd128(); b1 = rnd128(); o1 = $urandom;
    req_1 = 1'b1;
    push(1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!grant_1 && lat < 20);
    chk("abort_grant", grant_1, 1);
    req_1 = 1'b0;
    repeat (2 * CPC + 5) tick();
    chk("abort_col2", tx_col, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_txrst", txrst, 0);
    chk("abort_col", tx_col, 0);
    chk("abort_snap", tx_a | tx_b | tx_o, 0);
    void'(sb.pop_front());
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (400) begin
      tick();
      if (done_0 || done_1 || grant_0 || grant_1) n++;
    end
    chk("abort_no_done", n, 0);

    // pointer back at requester 0 after the abort
    a0 = rnd128(); a1 = rnd128();
    req_0 = 1'b1; req_1 = 1'b1;
    push(0);
    run_job("post_rst_tie", 1'b1, lat);

    // one-cycle request from producer 1 still runs the full job
    a1 = rnd128(); b1 = rnd128(); o1 = $urandom;
    req_1 = 1'b1;
    push(1);
    run_job("pulse_req1", 1'b1, lat);
    chk("pulse_req1_latency", lat, 1);

    // CYCLES_PER_COLUMN=2, GAP_CYCLES=1 corner build
    a0 = PAT_A; b0 = rnd128(); o0 = $urandom;
    c_req_0 = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!c_grant_0 && lat < 20);
    chk("corner_grant", c_grant_0, 1);
    chk("corner_latency", lat, 1);
    c_req_0 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("corner_col", c_tx_col, k / 2);
    end
    tick();
    chk("corner_done", c_done_0, 1);
    chk("corner_snap", c_tx_a, PAT_A);
    tick();
    chk("corner_gap_busy", c_busy, 1);
    tick();
    chk("corner_idle_busy", c_busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
